// File: rtl/calc_sequencer.sv
// Central controller of the tiny calculator: turns keypad tokens into hex
// operands, issues operations to the shared ALU and holds what the display shows.
module calc_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_key_data,
    input  logic             i_key_valid,
    output logic             o_key_ready,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    output logic             o_alu_valid,
    input  logic             i_alu_ready,
    input  logic [WIDTH-1:0] i_res_data,
    input  logic             i_res_err,
    input  logic             i_res_valid,
    output logic             o_res_ready,
    output logic [WIDTH-1:0] o_disp_value,
    output logic             o_disp_err,
    output logic             o_busy
);

    localparam int MAX_DIGITS = WIDTH / 4;
    localparam int CW         = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_WAIT = 3'd4,
        S_RES  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [1:0]       op_reg, op_next;
    logic [1:0]       pend_reg, pend_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             end_reg, end_next;

    // Token decode
    logic             is_digit;
    logic             is_oper;
    logic             is_eq;
    logic             is_ac;
    logic [1:0]       key_op;
    logic [WIDTH-1:0] digit;
    logic             key_fire;
    logic             count_full;

    assign is_digit   = ~i_key_data[4];
    assign is_ac      = (i_key_data == 5'b10000);
    assign is_eq      = (i_key_data == 5'b10101);
    assign is_oper    = i_key_data[4] && (i_key_data[3:0] >= 4'd1) && (i_key_data[3:0] <= 4'd4);
    assign key_op     = 2'(i_key_data[2:0] - 3'd1);
    assign digit      = WIDTH'(i_key_data[3:0]);
    assign key_fire   = i_key_valid && o_key_ready;
    assign count_full = (count_reg >= CW'(MAX_DIGITS));

    // State and datapath registers; reset is asynchronous so a mid-transfer
    // reset drops the handshake outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_A;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            pend_reg  <= '0;
            count_reg <= '0;
            end_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            pend_reg  <= pend_next;
            count_reg <= count_next;
            end_reg   <= end_next;
        end
    end

    // Next-state and datapath update for keys, ALU request and ALU result
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        pend_next  = pend_reg;
        count_next = count_reg;
        end_next   = end_reg;

        case (state_reg)
            S_A, S_OP, S_B, S_RES, S_ERR: begin
                if (key_fire) begin
                    if (is_ac) begin
                        a_next     = '0;
                        b_next     = '0;
                        op_next    = '0;
                        pend_next  = '0;
                        count_next = '0;
                        end_next   = 1'b0;
                        state_next = S_A;
                    end else if (state_reg != S_ERR) begin
                        if (is_digit) begin
                            case (state_reg)
                                S_A: begin
                                    // Full operand: digit is swallowed, nothing shifts out
                                    if (!count_full) begin
                                        a_next     = (a_reg << 4) | digit;
                                        count_next = count_reg + CW'(1);
                                    end
                                end
                                S_B: begin
                                    if (!count_full) begin
                                        b_next     = (b_reg << 4) | digit;
                                        count_next = count_reg + CW'(1);
                                    end
                                end
                                S_OP: begin
                                    b_next     = digit;
                                    count_next = CW'(1);
                                    state_next = S_B;
                                end
                                S_RES: begin
                                    // A new digit after a result starts a fresh calculation
                                    a_next     = digit;
                                    count_next = CW'(1);
                                    state_next = S_A;
                                end
                                default: ;
                            endcase
                        end else if (is_oper) begin
                            if (state_reg == S_B) begin
                                // Chained operator: run the pending op, remember the new one
                                pend_next  = key_op;
                                end_next   = 1'b0;
                                state_next = S_EXEC;
                            end else begin
                                op_next    = key_op;
                                state_next = S_OP;
                            end
                        end else if (is_eq && state_reg == S_B) begin
                            end_next   = 1'b1;
                            state_next = S_EXEC;
                        end
                    end
                end
            end
            S_EXEC: begin
                if (i_alu_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_res_valid) begin
                    if (i_res_err) begin
                        state_next = S_ERR;
                    end else begin
                        a_next     = i_res_data;
                        b_next     = '0;
                        count_next = '0;
                        if (end_reg) begin
                            state_next = S_RES;
                        end else begin
                            op_next    = pend_reg;
                            state_next = S_OP;
                        end
                    end
                end
            end
            default: state_next = S_A;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        o_key_ready  = (state_reg != S_EXEC) && (state_reg != S_WAIT);
        o_alu_valid  = (state_reg == S_EXEC);
        o_res_ready  = (state_reg == S_WAIT);
        o_busy       = (state_reg == S_EXEC) || (state_reg == S_WAIT);
        o_alu_a      = a_reg;
        o_alu_b      = b_reg;
        o_alu_op     = op_reg;
        o_disp_err   = (state_reg == S_ERR);
        o_disp_value = a_reg;
        if (state_reg == S_B) begin
            o_disp_value = b_reg;
        end else if (state_reg == S_ERR) begin
            o_disp_value = '0;
        end
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Central controller of the tiny calculator.
- Consumes 5-bit key tokens from the keypad scanner over valid/ready.
- Assembles hex operands A and B and issues operations to the shared ALU over a request/response handshake.
- Holds the value and error flag shown on the display.
- Sits between the keypad scanner (upstream), the ALU (downstream) and the display driver.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4. Derived: MAX_DIGITS = WIDTH/4.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_key_data  in  5  key token: 0dddd = hex digit d; 10000 AC, 10001 +, 10010 -, 10011 *, 10100 /, 10101 =; others reserved
i_key_valid  in  1  token valid
o_key_ready  out  1  token accepted when valid && ready
o_alu_a  out  WIDTH  operand A
o_alu_b  out  WIDTH  operand B
o_alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
o_alu_valid  out  1  ALU request valid
i_alu_ready  in  1  ALU accepts request
i_res_data  in  WIDTH  ALU result
i_res_err  in  1  result error (div by 0, overflow)
i_res_valid  in  1  result valid
o_res_ready  out  1  sequencer accepts result
o_disp_value  out  WIDTH  value to display
o_disp_err  out  1  display error indication
o_busy  out  1  high in S_EXEC and S_WAIT

Behaviour:
- States:
  - S_A: entering A
  - S_OP: operator latched, B empty
  - S_B: entering B
  - S_EXEC: ALU request pending
  - S_WAIT: awaiting result
  - S_RES: result shown
  - S_ERR: error
- Reset: state S_A. A, B, op, pending_op, digit count, end-after flag all 0. All outputs 0 except o_key_ready = 1.
- o_key_ready = 1 in S_A, S_OP, S_B, S_RES, S_ERR; 0 in S_EXEC, S_WAIT. Registered per state. Tokens arriving while busy stay stalled at the source.
- Digit d:
  - S_A: if count < MAX_DIGITS, A <= {A[WIDTH-5:0], d} and count++; else consumed and ignored.
  - S_B: same rule applied to B.
  - S_OP: B <= d, count = 1, go S_B.
  - S_RES: A <= d, count = 1, go S_A.
  - S_ERR: ignored.
- Operator (+ - * /), encoded op = token[2:0] - 1:
  - S_A, S_OP, S_RES: latch op (replaces any prior op); go S_OP. In S_RES, A already holds the result.
  - S_B: chain. Issue A op B, latch the new operator into pending_op, end_after = 0, go S_EXEC.
  - S_ERR: ignored.
- '=':
  - S_B: issue A op B, end_after = 1, go S_EXEC.
  - Other accepting states: consumed, no effect.
- AC in any accepting state: clear A, B, op, count; go S_A next cycle.
- Reserved codes: consumed, no effect.
- S_EXEC:
  - o_alu_valid = 1; o_alu_a/b/op held stable until i_alu_ready is sampled high.
  - Transfer cycle: go S_WAIT; o_alu_valid = 0 from the next cycle.
  - Request latency: 1 cycle from key accept to o_alu_valid.
- S_WAIT: o_res_ready = 1. On i_res_valid:
  - If i_res_err: go S_ERR.
  - Else A <= i_res_data, B <= 0, count = 0. Go S_RES if end_after, else S_OP with op <= pending_op.
  - A result arriving in the same cycle as the request transfer is not accepted (o_res_ready still 0).
- Display:
  - o_disp_value = B in S_B; A in all other states; 0 in S_ERR.
  - o_disp_err = 1 only in S_ERR. S_ERR exits only via AC.
- No arithmetic inside the block; digit shift discards nothing because of the count limit.
- Asynchronous reset mid-transaction drops o_alu_valid and o_res_ready immediately. The ALU must tolerate an abandoned transaction.

Test Plan:
- Reset, keys 1,2,+,3,= with i_alu_ready = 1 and result 0x0015 two cycles after the request -> alu_a = 0x0012, alu_b = 0x0003, op = 00; S_RES; disp = 0x0015.
- Keys F,F,F,F,1 (WIDTH = 16) -> fifth digit consumed and ignored; disp = 0xFFFF.
- Keys 8,*,2,-: ALU holds i_alu_ready = 0 for 5 cycles -> o_alu_valid and operands stable all 5 cycles; o_key_ready = 0. Result 0x10 -> state S_OP with op = 01; disp = 0x0010.
- Keys 5,/,0,= with i_res_err = 1 -> o_disp_err = 1, disp = 0. Digits and '=' ignored; AC -> S_A with disp = 0 and err = 0.
- Keys 3,+,-,4,= -> operator replaced; request op = 01, a = 3, b = 4.
- Assert rst_n low during S_EXEC -> o_alu_valid = 0 asynchronously. After release: S_A, disp = 0, o_key_ready = 1.
